// File: rtl/mreq_executor_if.sv
// Port bundle between the MREQ arbiter side and the executor: request, write/read
// data streams and the Wishbone-classic master signals.
interface mreq_executor_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MREQ_NBIT = ADDR_W + CNT_W + 2;

  logic                 i_mreq_valid;
  logic                 o_mreq_ready;
  logic [MREQ_NBIT-1:0] i_mreq;
  logic                 i_wdata_valid;
  logic                 o_wdata_ready;
  logic [DATA_W-1:0]    i_wdata;
  logic                 o_rdata_valid;
  logic                 i_rdata_ready;
  logic [DATA_W-1:0]    o_rdata;
  logic                 o_wb_cyc;
  logic                 o_wb_stb;
  logic                 o_wb_we;
  logic [ADDR_W-1:0]    o_wb_adr;
  logic [DATA_W-1:0]    o_wb_dat;
  logic [DATA_W-1:0]    i_wb_dat;
  logic                 i_wb_ack;
  logic                 o_busy;
  logic                 o_timeout;

  // Executor side
  modport slave (
    input  i_mreq_valid, i_mreq, i_wdata_valid, i_wdata, i_rdata_ready, i_wb_dat, i_wb_ack,
    output o_mreq_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_wb_cyc, o_wb_stb,
           o_wb_we, o_wb_adr, o_wb_dat, o_busy, o_timeout
  );

  // Arbiter / stream / bus-slave side
  modport master (
    output i_mreq_valid, i_mreq, i_wdata_valid, i_wdata, i_rdata_ready, i_wb_dat, i_wb_ack,
    input  o_mreq_ready, o_wdata_ready, o_rdata_valid, o_rdata, o_wb_cyc, o_wb_stb,
           o_wb_we, o_wb_adr, o_wb_dat, o_busy, o_timeout
  );
endinterface

// File: rtl/mreq_executor.sv
// Executes one accepted MREQ as a burst of Wishbone-classic single transfers, with a
// per-beat bus timeout that substitutes a dummy beat so stream lengths stay exact.
module mreq_executor #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  mreq_executor_if.slave bus
);
  localparam int unsigned MREQ_NBIT = ADDR_W + CNT_W + 2;
  localparam int unsigned TMR_W     = $clog2(TIMEOUT_CYC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_BUS   = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 inc_q, inc_d;
  logic                 wr_q, wr_d;
  logic [DATA_W-1:0]    wdat_q, wdat_d;
  logic [DATA_W-1:0]    rdat_q, rdat_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 mreq_rdy_q, mreq_rdy_d;
  logic                 wdata_rdy_q, wdata_rdy_d;
  logic                 rdata_vld_q, rdata_vld_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;
  logic                 advance;
  logic [MREQ_NBIT-1:0] mreq;

  assign mreq = bus.i_mreq;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    inc_d   = inc_q;
    wr_d    = wr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    tmr_d   = tmr_q;
    tmo_d   = 1'b0;
    advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_mreq_valid && mreq_rdy_q) begin
          addr_d  = mreq[MREQ_NBIT-1 -: ADDR_W];
          cnt_d   = mreq[2 +: CNT_W];
          inc_d   = mreq[1];
          wr_d    = mreq[0];
          tmr_d   = '0;
          state_d = mreq[0] ? S_WDATA : S_BUS;
        end
      end
      S_WDATA: begin
        if (bus.i_wdata_valid && wdata_rdy_q) begin
          wdat_d  = bus.i_wdata;
          tmr_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // A real ack on the last allowed cycle takes precedence over the timeout
        if (cyc_q && (bus.i_wb_ack || (tmr_q == TMR_W'(TIMEOUT_CYC - 1)))) begin
          tmo_d = !bus.i_wb_ack;
          if (wr_q) begin
            advance = 1'b1;
          end else begin
            rdat_d  = bus.i_wb_ack ? bus.i_wb_dat : '1;
            state_d = S_RDATA;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_RDATA: begin
        if (bus.i_rdata_ready && rdata_vld_q) advance = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (cnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
        addr_d  = addr_q + ADDR_W'(inc_q);
        tmr_d   = '0;
        state_d = wr_q ? S_WDATA : S_BUS;
      end
    end

    mreq_rdy_d  = (state_d == S_IDLE);
    wdata_rdy_d = (state_d == S_WDATA);
    rdata_vld_d = (state_d == S_RDATA);
    cyc_d       = (state_d == S_BUS);
    we_d        = (state_d == S_BUS) && wr_d;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      inc_q       <= 1'b0;
      wr_q        <= 1'b0;
      wdat_q      <= '0;
      rdat_q      <= '0;
      tmr_q       <= '0;
      mreq_rdy_q  <= 1'b0;
      wdata_rdy_q <= 1'b0;
      rdata_vld_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      inc_q       <= inc_d;
      wr_q        <= wr_d;
      wdat_q      <= wdat_d;
      rdat_q      <= rdat_d;
      tmr_q       <= tmr_d;
      mreq_rdy_q  <= mreq_rdy_d;
      wdata_rdy_q <= wdata_rdy_d;
      rdata_vld_q <= rdata_vld_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.o_mreq_ready  = mreq_rdy_q;
  assign bus.o_wdata_ready = wdata_rdy_q;
  assign bus.o_rdata_valid = rdata_vld_q;
  assign bus.o_rdata       = rdat_q;
  assign bus.o_wb_cyc      = cyc_q;
  assign bus.o_wb_stb      = cyc_q;
  assign bus.o_wb_we       = we_q;
  assign bus.o_wb_adr      = addr_q;
  assign bus.o_wb_dat      = wdat_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_timeout     = tmo_q;
endmodule

// File: tb/tb_mreq_executor.sv
// Bench for mreq_executor: randomized streams and bus slave, expected addresses and
// data derived from the request fields with plain arithmetic.
module tb_mreq_executor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mreq_executor_if ifc ();
  mreq_executor dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  int checks = 0;
  int failures = 0;

  // stream / slave state
  logic [31:0] wq[$];
  logic [31:0] sent[$];
  logic [15:0] exp_adr[$];
  logic [31:0] obs_rd[$];
  logic [31:0] sup_rd[$];
  beat_t       obs_beats[$];
  int          beat_len[$];
  int whs = 0, rd_stall = 0, stall_cnt = 0, stab_err = 0;
  int max_delay = 0, noack_beat = -1, beat_idx = 0, wait_cnt = 0, delay = 0, stb_len = 0;
  int to_cnt = 0, to_err = 0;
  bit gaps_en = 0, fixed_en = 0, stb_prev = 0, noack_now = 0, to_prev = 0, hung = 0;
  logic [31:0] fixed_val = '0, rdv = '0, held = '0;

  // Wishbone slave: random ack latency, optional never-ack beat
  always @(negedge clk) begin
    ifc.i_wb_ack = 1'b0;
    if (ifc.o_wb_stb) begin
      if (!stb_prev) begin
        obs_beats.push_back('{ifc.o_wb_adr, ifc.o_wb_we, ifc.o_wb_dat});
        noack_now = (beat_idx == noack_beat);
        delay = $urandom_range(0, max_delay);
        rdv = fixed_en ? fixed_val : $urandom;
        if (!ifc.o_wb_we) sup_rd.push_back(noack_now ? 32'hFFFF_FFFF : rdv);
        beat_idx++;
        wait_cnt = 0;
        stb_len = 0;
      end
      stb_len++;
      if (!noack_now && wait_cnt >= delay) begin
        ifc.i_wb_ack = 1'b1;
        ifc.i_wb_dat = rdv;
      end
      wait_cnt++;
      if (ifc.o_timeout) to_err++;
    end else if (stb_prev) begin
      beat_len.push_back(stb_len);
    end
    if (ifc.o_timeout) begin
      to_cnt++;
      if (to_prev) to_err++;
    end
    to_prev = ifc.o_timeout;
    stb_prev = ifc.o_wb_stb;
  end

  // Read-data sink: optional fixed stall per beat, checks data held while stalled
  always @(negedge clk) begin
    if (ifc.o_rdata_valid) begin
      if (stall_cnt == 0) held = ifc.o_rdata;
      else if (ifc.o_rdata !== held) stab_err++;
      if (stall_cnt < rd_stall) begin
        ifc.i_rdata_ready = 1'b0;
        stall_cnt++;
      end else begin
        ifc.i_rdata_ready = 1'b1;
        obs_rd.push_back(ifc.o_rdata);
        stall_cnt = 0;
      end
    end else begin
      ifc.i_rdata_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  // Write-data source with optional random valid gaps
  always @(negedge clk) begin
    if (wq.size() > 0) begin
      if (gaps_en && $urandom_range(0, 2) == 0) begin
        ifc.i_wdata_valid = 1'b0;
      end else begin
        ifc.i_wdata_valid = 1'b1;
        ifc.i_wdata = wq[0];
        if (ifc.o_wdata_ready) begin
          void'(wq.pop_front());
          whs++;
        end
      end
    end else begin
      ifc.i_wdata_valid = 1'b0;
    end
  end

  task automatic clear_obs();
    obs_beats.delete(); sup_rd.delete(); obs_rd.delete(); beat_len.delete();
    sent.delete(); exp_adr.delete(); wq.delete();
    whs = 0; beat_idx = 0; to_cnt = 0; to_err = 0; stab_err = 0; hung = 0;
  endtask

  // Issue one MREQ, build the expected beat list, wait for the burst to finish
  task automatic run_burst(input logic [15:0] a, input int c, input bit inc_b,
                           input bit wr_b, input bit seqdata);
    logic [31:0] v;
    int n;
    clear_obs();
    for (int k = 0; k <= c; k++) begin
      exp_adr.push_back(16'(int'(a) + k * int'(inc_b)));
      if (wr_b) begin
        v = seqdata ? 32'(k + 1) : $urandom;
        sent.push_back(v);
        wq.push_back(v);
      end
    end
    @(negedge clk);
    ifc.i_mreq = {a, 8'(c), inc_b, wr_b};
    ifc.i_mreq_valid = 1'b1;
    n = 0;
    while (!ifc.o_mreq_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) hung = 1;
    @(posedge clk); #1;
    ifc.i_mreq_valid = 1'b0;
    n = 0;
    while (ifc.o_busy && n < 5000) begin @(posedge clk); #1; n++; end
    if (n >= 5000) hung = 1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    logic [87:0] ov;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ov = {ifc.o_mreq_ready, ifc.o_wdata_ready, ifc.o_rdata_valid, ifc.o_wb_cyc, ifc.o_wb_stb,
          ifc.o_wb_we, ifc.o_busy, ifc.o_timeout, ifc.o_wb_adr, ifc.o_wb_dat, ifc.o_rdata};
    checks++;
    if (ov !== '0) begin failures++; $display("FAIL reset_outputs: got %h exp 0", ov); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ifc.o_mreq_ready !== 1'b1) begin
      failures++; $display("FAIL reset_mreq_ready: got %b exp 1", ifc.o_mreq_ready);
    end
  endtask

  task automatic test_read_single();
    clear_obs();
    fixed_en = 1; fixed_val = 32'hCAFE_F00D; max_delay = 0; noack_beat = -1; rd_stall = 0;
    @(negedge clk);
    ifc.i_mreq = {16'h0010, 8'd0, 1'b1, 1'b0};
    ifc.i_mreq_valid = 1'b1;
    checks++;
    if (ifc.o_mreq_ready !== 1'b1) begin
      failures++; $display("FAIL rd1_ready_c0: got %b exp 1", ifc.o_mreq_ready);
    end
    @(posedge clk); #1;
    ifc.i_mreq_valid = 1'b0;
    checks++;
    if ({ifc.o_wb_stb, ifc.o_wb_we, ifc.o_wb_adr} !== {1'b1, 1'b0, 16'h0010}) begin
      failures++; $display("FAIL rd1_bus_c1: got stb=%b we=%b adr=%h exp 1 0 0010",
                           ifc.o_wb_stb, ifc.o_wb_we, ifc.o_wb_adr);
    end
    @(posedge clk); #1;
    checks++;
    if ({ifc.o_rdata_valid, ifc.o_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL rd1_rdata_c2: got v=%b d=%h exp 1 cafef00d",
                           ifc.o_rdata_valid, ifc.o_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({ifc.o_mreq_ready, ifc.o_busy} !== 2'b10) begin
      failures++; $display("FAIL rd1_idle_c3: got rdy=%b busy=%b exp 1 0",
                           ifc.o_mreq_ready, ifc.o_busy);
    end
    checks++;
    if (obs_rd.size() !== 1 || obs_beats.size() !== 1) begin
      failures++; $display("FAIL rd1_counts: got rd=%0d beats=%0d exp 1 1",
                           obs_rd.size(), obs_beats.size());
    end
    fixed_en = 0;
  endtask

  task automatic test_write_burst();
    gaps_en = 1; max_delay = 2; noack_beat = -1;
    run_burst(16'h0100, 3, 1'b1, 1'b1, 1'b1);
    checks++;
    if (hung !== 1'b0 || obs_beats.size() !== 4 || whs !== 4) begin
      failures++; $display("FAIL wr_counts: got hung=%b beats=%0d whs=%0d exp 0 4 4",
                           hung, obs_beats.size(), whs);
    end
    for (int k = 0; k < obs_beats.size() && k < 4; k++) begin
      checks++;
      if ({obs_beats[k].adr, obs_beats[k].we, obs_beats[k].dat} !==
          {16'(16'h0100 + k), 1'b1, 32'(k + 1)}) begin
        failures++; $display("FAIL wr_beat%0d: got adr=%h we=%b dat=%h exp %h 1 %h", k,
                             obs_beats[k].adr, obs_beats[k].we, obs_beats[k].dat,
                             16'(16'h0100 + k), 32'(k + 1));
      end
    end
    gaps_en = 0;
  endtask

  task automatic test_read_stall();
    logic [15:0] a;
    a = 16'($urandom);
    rd_stall = 5; max_delay = 1; noack_beat = -1;
    run_burst(a, 2, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hung !== 1'b0 || obs_beats.size() !== 3 || obs_rd.size() !== 3 || stab_err !== 0) begin
      failures++; $display("FAIL rs_counts: got hung=%b beats=%0d rd=%0d unstable=%0d exp 0 3 3 0",
                           hung, obs_beats.size(), obs_rd.size(), stab_err);
    end
    for (int k = 0; k < obs_beats.size() && k < 3; k++) begin
      checks++;
      if ({obs_beats[k].adr, obs_beats[k].we, obs_rd[k]} !== {a, 1'b0, sup_rd[k]}) begin
        failures++; $display("FAIL rs_beat%0d: got adr=%h we=%b d=%h exp %h 0 %h", k,
                             obs_beats[k].adr, obs_beats[k].we, obs_rd[k], a, sup_rd[k]);
      end
    end
    rd_stall = 0;
  endtask

  task automatic test_timeout();
    max_delay = 0; noack_beat = 0;
    run_burst(16'h2000, 1, 1'b1, 1'b0, 1'b0);
    noack_beat = -1;
    checks++;
    if (hung !== 1'b0 || obs_beats.size() !== 2 || to_cnt !== 1 || to_err !== 0) begin
      failures++; $display("FAIL to_counts: got hung=%b beats=%0d pulses=%0d bad=%0d exp 0 2 1 0",
                           hung, obs_beats.size(), to_cnt, to_err);
    end
    checks++;
    if (beat_len.size() < 1 || beat_len[0] !== 255) begin
      failures++; $display("FAIL to_stb_len: got %0d exp 255",
                           (beat_len.size() > 0) ? beat_len[0] : -1);
    end
    checks++;
    if (obs_rd.size() !== 2 || obs_rd[0] !== 32'hFFFF_FFFF || obs_rd[1] !== sup_rd[1]) begin
      failures++; $display("FAIL to_rdata: got n=%0d d0=%h exp 2 ffffffff", obs_rd.size(),
                           (obs_rd.size() > 0) ? obs_rd[0] : 32'h0);
    end
    checks++;
    if (obs_beats.size() > 1 && obs_beats[1].adr !== 16'h2001) begin
      failures++; $display("FAIL to_beat1_adr: got %h exp 2001", obs_beats[1].adr);
    end
  endtask

  task automatic test_addr_wrap();
    max_delay = 1;
    run_burst(16'hFFFF, 1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (hung !== 1'b0 || obs_beats.size() !== 2 || whs !== 2) begin
      failures++; $display("FAIL wrap_counts: got hung=%b beats=%0d whs=%0d exp 0 2 2",
                           hung, obs_beats.size(), whs);
    end
    checks++;
    if (obs_beats.size() == 2 &&
        ({obs_beats[0].adr, obs_beats[1].adr} !== {16'hFFFF, 16'h0000} ||
         obs_beats[0].dat !== sent[0] || obs_beats[1].dat !== sent[1])) begin
      failures++; $display("FAIL wrap_beats: got %h/%h %h/%h exp ffff/%h 0000/%h",
                           obs_beats[0].adr, obs_beats[0].dat, obs_beats[1].adr,
                           obs_beats[1].dat, sent[0], sent[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [87:0] ov;
    clear_obs();
    max_delay = 0; noack_beat = 0;
    @(negedge clk);
    ifc.i_mreq = {16'h1234, 8'd5, 1'b1, 1'b0};
    ifc.i_mreq_valid = 1'b1;
    @(posedge clk); #1;
    ifc.i_mreq_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ifc.o_wb_stb !== 1'b1) begin
      failures++; $display("FAIL rstmid_in_bus: got stb=%b exp 1", ifc.o_wb_stb);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    ov = {ifc.o_mreq_ready, ifc.o_wdata_ready, ifc.o_rdata_valid, ifc.o_wb_cyc, ifc.o_wb_stb,
          ifc.o_wb_we, ifc.o_busy, ifc.o_timeout, ifc.o_wb_adr, ifc.o_wb_dat, ifc.o_rdata};
    checks++;
    if (ov !== '0) begin failures++; $display("FAIL rstmid_outputs: got %h exp 0", ov); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({ifc.o_mreq_ready, ifc.o_busy} !== 2'b10) begin
      failures++; $display("FAIL rstmid_ready: got rdy=%b busy=%b exp 1 0",
                           ifc.o_mreq_ready, ifc.o_busy);
    end
    noack_beat = -1;
    run_burst(16'h0040, 2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (hung !== 1'b0 || obs_beats.size() !== 3 || obs_rd.size() !== 3 || to_cnt !== 0) begin
      failures++; $display("FAIL rstmid_after: got hung=%b beats=%0d rd=%0d to=%0d exp 0 3 3 0",
                           hung, obs_beats.size(), obs_rd.size(), to_cnt);
    end
    for (int k = 0; k < obs_rd.size() && k < 3; k++) begin
      checks++;
      if ({obs_beats[k].adr, obs_rd[k]} !== {exp_adr[k], sup_rd[k]}) begin
        failures++; $display("FAIL rstmid_beat%0d: got %h/%h exp %h/%h", k,
                             obs_beats[k].adr, obs_rd[k], exp_adr[k], sup_rd[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    bit w, i;
    for (int t = 0; t < 6; t++) begin
      c = $urandom_range(0, 7);
      w = 1'($urandom_range(0, 1));
      i = 1'($urandom_range(0, 1));
      max_delay = $urandom_range(0, 3);
      rd_stall = $urandom_range(0, 2);
      gaps_en = 1'($urandom_range(0, 1));
      run_burst(16'($urandom), c, i, w, 1'b0);
      checks++;
      if (hung !== 1'b0 || obs_beats.size() !== c + 1 || to_cnt !== 0 ||
          (w ? whs : obs_rd.size()) !== c + 1) begin
        failures++; $display("FAIL b2b%0d_counts: got hung=%b beats=%0d strm=%0d exp 0 %0d %0d",
                             t, hung, obs_beats.size(), w ? whs : obs_rd.size(), c + 1, c + 1);
      end
      for (int k = 0; k < obs_beats.size() && k <= c; k++) begin
        checks++;
        if (obs_beats[k].adr !== exp_adr[k] || obs_beats[k].we !== w ||
            (w && obs_beats[k].dat !== sent[k]) ||
            (!w && k < obs_rd.size() && obs_rd[k] !== sup_rd[k])) begin
          failures++; $display("FAIL b2b%0d_beat%0d: got adr=%h we=%b exp adr=%h we=%b",
                               t, k, obs_beats[k].adr, obs_beats[k].we, exp_adr[k], w);
        end
      end
    end
    rd_stall = 0; gaps_en = 0;
  endtask

  initial begin
    ifc.i_mreq_valid = 1'b0;
    ifc.i_mreq = '0;
    ifc.i_wdata_valid = 1'b0;
    ifc.i_wdata = '0;
    ifc.i_rdata_ready = 1'b0;
    ifc.i_wb_dat = '0;
    ifc.i_wb_ack = 1'b0;
    test_reset();
    test_read_single();
    test_write_burst();
    test_read_stall();
    test_timeout();
    test_addr_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
